// File: rtl/cen_gen_pkg.sv
// -----------------------------------------------------------------------------
// cen_gen_pkg
//   Shared definitions for the fractional clock-enable generator:
//   - seq_state_e : start-up sequencer states
//   - clog2       : ceiling log2 used to size the settle counter
//   - cnt_width   : settle-counter width (never narrower than one bit)
// -----------------------------------------------------------------------------
package cen_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >>> 1;
      end
    end
    return r;
  endfunction

  // The counter only has to hold 0 .. lock_delay-1.
  function automatic int cnt_width(input int lock_delay);
    int w;
    w = clog2(lock_delay);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cen_gen_channel.sv
// -----------------------------------------------------------------------------
// cen_gen_channel
//   One fractional enable channel: a phase accumulator that adds mul every
//   active cycle and wraps modulo div, emitting a one-cycle cen pulse on each
//   wrap. Average pulse rate is clk * mul / div.
//
// Ports
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   active in  channel may accumulate this cycle (sequencer in RUN and en set)
//   mul    in  numerator, sampled every cycle
//   div    in  denominator, sampled every cycle
//   cen    out registered one-cycle enable pulse
//   err    out registered configuration error (div = 0 or mul > div)
// -----------------------------------------------------------------------------
module cen_gen_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [WIDTH-1:0] mul,
  input  logic [WIDTH-1:0] div,
  output logic             cen,
  output logic             err
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             cen_q;
  logic             cen_d;
  logic             err_q;
  logic             err_d;

  // One extra bit so acc + mul never overflows (acc < div <= 2^WIDTH-1).
  logic [WIDTH:0]   sum;
  logic             div_zero;
  logic             mul_over;

  always_comb begin
    div_zero = (div == '0);
    mul_over = (mul > div);
    sum      = {1'b0, acc_q} + {1'b0, mul};

    // The error flag tracks the configuration regardless of sequencer state.
    err_d    = div_zero | mul_over;

    acc_d    = acc_q;
    cen_d    = 1'b0;

    if (!active || div_zero) begin
      // Parked: restart phase from zero so re-enabling is deterministic.
      acc_d = '0;
      cen_d = 1'b0;
    end else if (mul_over) begin
      // Rate above clk cannot be met; saturate to an every-cycle enable.
      acc_d = '0;
      cen_d = 1'b1;
    end else if (acc_q >= div) begin
      // div was lowered below the stored phase: treat as an immediate wrap
      // so acc < div holds again after this edge.
      acc_d = '0;
      cen_d = 1'b1;
    end else if (sum >= {1'b0, div}) begin
      acc_d = WIDTH'(sum - {1'b0, div});
      cen_d = 1'b1;
    end else begin
      acc_d = sum[WIDTH-1:0];
      cen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cen_q <= cen_d;
      err_q <= err_d;
    end
  end

  assign cen = cen_q;
  assign err = err_q;

endmodule

// File: rtl/cen_gen.sv
// -----------------------------------------------------------------------------
// cen_gen
//   Multi-channel fractional clock-enable generator. Each channel produces
//   one-cycle cen pulses at an average rate of clk * mul / div. Start-up is
//   gated by the PLL lock: enables stay silent until lock has been stable for
//   LOCK_DELAY cycles and stop as soon as lock is lost.
//
// Parameters
//   CHANNELS   number of independent enable channels
//   WIDTH      bit width of each channel's mul / div
//   LOCK_DELAY cycles (>= 1) of stable synchronised lock before ready
//
// Ports
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   locked in  PLL lock, asynchronous to clk
//   en     in  [CHANNELS]          per-channel run enable
//   mul    in  [CHANNELS*WIDTH]    numerators, channel i at [i*WIDTH +: WIDTH]
//   div    in  [CHANNELS*WIDTH]    denominators, same packing
//   cen    out [CHANNELS]          per-channel enable pulse
//   err    out [CHANNELS]          per-channel configuration error
//   ready  out                     high while the sequencer is in RUN
// -----------------------------------------------------------------------------
module cen_gen
  import cen_gen_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 16,
  parameter int LOCK_DELAY = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      locked,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] mul,
  input  logic [CHANNELS*WIDTH-1:0] div,
  output logic [CHANNELS-1:0]       cen,
  output logic [CHANNELS-1:0]       err,
  output logic                      ready
);

  localparam int             CNT_W    = cnt_width(LOCK_DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);

  // Lock synchroniser
  logic sync1_q;
  logic sync1_d;
  logic lock_s_q;
  logic lock_s_d;

  // Sequencer
  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ready_q;
  logic             ready_d;
  logic             run_ok;

  always_comb begin
    sync1_d  = locked;
    lock_s_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      lock_s_q <= lock_s_d;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_s_q) state_d = SETTLE;
      SETTLE: begin
        if (!lock_s_q)             state_d = WAIT_LOCK;
        else if (cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN:       if (!lock_s_q) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // Output logic
  always_comb begin
    // Counter runs only while settling; any other state restarts it.
    cnt_d   = (state_q == SETTLE) ? cnt_q + CNT_W'(1) : '0;
    // ready is registered from the next state so it is high exactly in RUN.
    ready_d = (state_d == RUN);
    // Channels stop on the same edge that leaves RUN, so no pulse is emitted
    // once the synchronised lock has dropped.
    run_ok  = (state_q == RUN) && lock_s_q;
  end

  assign ready = ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cen_gen_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .active (run_ok & en[i]),
      .mul    (mul[i*WIDTH +: WIDTH]),
      .div    (div[i*WIDTH +: WIDTH]),
      .cen    (cen[i]),
      .err    (err[i])
    );
  end

endmodule

// File: tb/tb_cen_gen.sv
module tb_cen_gen;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int LD = 16;

  logic            clk;
  logic            rst;
  logic            locked;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] mul;
  logic [CH*W-1:0] div;
  logic [CH-1:0]   cen;
  logic [CH-1:0]   err;
  logic            ready;

  int tests;
  int fails;

  cen_gen #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .LOCK_DELAY (LD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .locked (locked),
    .en     (en),
    .mul    (mul),
    .div    (div),
    .cen    (cen),
    .err    (err),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int m;
    int d;
    int cycles;
    int exp_pulses;
    int exp_err;
  } vec_t;

  // Reference: after n active cycles from a zero phase, the number of pulses is
  // floor(n*mul/div); a pulse falls on cycle n when that count steps up.
  function automatic int exp_cen(input longint n, input longint m, input longint d);
    if (d == 0) return 0;
    if (m > d) return 1;
    return (((n * m) / d) != (((n - 1) * m) / d)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[10];
    int   pulses;
    int   pos_bad;
    int   m_r[CH];
    int   d_r[CH];

    tests = 0;
    fails = 0;

    vt[0] = '{1, 8, 24, 3, 0};
    vt[1] = '{3, 8, 24, 9, 0};
    vt[2] = '{8, 8, 24, 24, 0};
    vt[3] = '{0, 8, 24, 0, 0};
    vt[4] = '{9, 4, 24, 24, 1};
    vt[5] = '{5, 0, 24, 0, 1};
    vt[6] = '{7, 10, 20, 14, 0};
    vt[7] = '{65535, 65535, 24, 24, 0};
    vt[8] = '{1, 65535, 24, 0, 0};
    vt[9] = '{65534, 65535, 24, 23, 0};

    rst    = 1'b1;
    locked = 1'b0;
    en     = '0;
    mul    = '0;
    div    = '0;
    repeat (3) tick();
    check("reset_cen", cen, 0);
    check("reset_err", err, 0);
    check("reset_ready", ready, 0);

    // Start-up: lock first sampled at edge 10, ready expected after 10+2+LD.
    mul[0*W +: W] = 16'd1; div[0*W +: W] = 16'd1;
    mul[1*W +: W] = 16'd1; div[1*W +: W] = 16'd1;
    en  = 2'b11;
    rst = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 10) locked = 1'b1;
      tick();
      check($sformatf("startup_ready_e%0d", e), ready, (e >= 10 + 2 + LD) ? 1 : 0);
      if (e <= 10 + 2 + LD) check($sformatf("startup_cen_e%0d", e), cen, 0);
      if (e == 10 + 2 + LD + 1) check("startup_first_cen", cen, 3);
    end
    check("startup_err", err, 0);

    // Table-driven rates on channel 0, channel 1 parked.
    en = '0;
    mul[1*W +: W] = 16'd0; div[1*W +: W] = 16'd1;
    for (int r = 0; r < 10; r++) begin
      en = '0;
      tick();
      mul[0*W +: W] = W'(vt[r].m);
      div[0*W +: W] = W'(vt[r].d);
      en = 2'b01;
      pulses = 0;
      for (int c = 0; c < vt[r].cycles; c++) begin
        tick();
        pulses += int'(cen[0]);
      end
      check($sformatf("tbl%0d_pulses", r), pulses, vt[r].exp_pulses);
      check($sformatf("tbl%0d_err", r), err[0], vt[r].exp_err);
      check($sformatf("tbl%0d_ch1_idle", r), cen[1], 0);
    end

    // 6 MHz from 48 MHz: mul=1, div=8 over 8000 cycles.
    en = '0;
    tick();
    mul[0*W +: W] = 16'd1;
    div[0*W +: W] = 16'd8;
    en = 2'b01;
    pulses  = 0;
    pos_bad = 0;
    for (int n = 1; n <= 8000; n++) begin
      tick();
      pulses += int'(cen[0]);
      if (int'(cen[0]) != exp_cen(n, 1, 8)) pos_bad++;
    end
    check("div8_count", pulses, 1000);
    check("div8_position_errors", pos_bad, 0);

    // Randomised configurations on both channels.
    for (int it = 0; it < 30; it++) begin
      en = '0;
      tick();
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 3) == 0) begin
          d_r[ch] = int'($urandom_range(1000, 65535));
          m_r[ch] = int'($urandom_range(0, d_r[ch]));
        end else begin
          d_r[ch] = int'($urandom_range(0, 40));
          m_r[ch] = int'($urandom_range(0, d_r[ch] + 3));
        end
        mul[ch*W +: W] = W'(m_r[ch]);
        div[ch*W +: W] = W'(d_r[ch]);
        en[ch] = 1'($urandom_range(0, 1));
      end
      for (int n = 1; n <= 40; n++) begin
        tick();
        for (int ch = 0; ch < CH; ch++)
          check($sformatf("rnd%0d_ch%0d_n%0d_cen", it, ch, n), cen[ch],
                en[ch] ? exp_cen(n, m_r[ch], d_r[ch]) : 0);
      end
      for (int ch = 0; ch < CH; ch++)
        check($sformatf("rnd%0d_ch%0d_err", it, ch), err[ch],
              (d_r[ch] == 0 || m_r[ch] > d_r[ch]) ? 1 : 0);
    end

    // div lowered from 100 to 5 while acc = 60.
    en = '0;
    mul[1*W +: W] = 16'd0; div[1*W +: W] = 16'd1;
    tick();
    mul[0*W +: W] = 16'd1;
    div[0*W +: W] = 16'd100;
    en = 2'b01;
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      pulses += int'(cen[0]);
    end
    check("divchg_quiet", pulses, 0);
    div[0*W +: W] = 16'd5;
    for (int n = 0; n <= 10; n++) begin
      tick();
      check($sformatf("divchg_cen%0d", n), cen[0], (n % 5 == 0) ? 1 : 0);
    end

    // One-cycle lock drop in RUN, then relock.
    en = '0;
    tick();
    mul[0*W +: W] = 16'd3;
    div[0*W +: W] = 16'd8;
    en = 2'b01;
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    check("drop_ready_j1", ready, 1);
    tick();
    check("drop_ready_j2", ready, 0);
    check("drop_cen_j2", cen, 0);
    for (int t = 3; t <= 3 + LD; t++) begin
      tick();
      check($sformatf("relock_ready_t%0d", t), ready, (t >= 3 + LD) ? 1 : 0);
      check($sformatf("relock_cen_t%0d", t), cen, 0);
    end
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("relock_seq_n%0d", n), cen[0], exp_cen(n, 3, 8));
    end

    // Error channels, then asynchronous reset mid-run.
    en = '0;
    tick();
    mul[0*W +: W] = 16'd5; div[0*W +: W] = 16'd0;
    mul[1*W +: W] = 16'd9; div[1*W +: W] = 16'd4;
    en = 2'b11;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("errch_cen_n%0d", n), cen, 2'b10);
    end
    check("errch_err", err, 2'b11);
    check("errch_ready", ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cen", cen, 0);
    check("async_rst_err", err, 0);
    check("async_rst_ready", ready, 0);
    tick();
    check("rst_held_ready", ready, 0);
    check("rst_held_cen", cen, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cen_gen.md
# cen_gen

Multi-channel fractional clock-enable generator driven from the single PLL system clock (48 MHz in the current build). Each channel emits one-cycle `cen` pulses at an average rate of clk × mul/div, so CPU, sound and video logic run from one clock domain with no extra PLL outputs. The block sequences start-up from the PLL `locked` signal: enables stay silent until lock has been stable for a programmable settle time, and they stop immediately if lock is lost.

## Interface
- `CHANNELS`, default 2: number of independent enable channels.
- `WIDTH`, default 16: bit width of each channel's `mul` and `div` values.
- `LOCK_DELAY`, default 1024: cycles (≥1) of stable synchronised lock required before `ready` asserts.

- `clk` in 1: system clock, single domain.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock; asynchronous to `clk`, synchronised internally.
- `en` in CHANNELS: per-channel run enable.
- `mul` in CHANNELS×WIDTH: per-channel numerator; channel i occupies bits [i*WIDTH +: WIDTH].
- `div` in CHANNELS×WIDTH: per-channel denominator, same packing as `mul`.
- `cen` out CHANNELS: per-channel one-cycle enable pulse.
- `err` out CHANNELS: per-channel configuration error flag.
- `ready` out 1: high while the sequencer is in RUN.

## Operation
- Reset values: `cen`=0, `err`=0, `ready`=0, accumulators=0, sync flops=0, state=WAIT_LOCK.
- **Lock synchroniser:** two flops; `lock_s` is the second-stage output.
- **Sequencer states:**
  - WAIT_LOCK: go to SETTLE when `lock_s`=1. Clear the settle counter.
  - SETTLE: counter increments each cycle. Go to RUN when counter = LOCK_DELAY-1. Return to WAIT_LOCK if `lock_s`=0.
  - RUN: go to WAIT_LOCK when `lock_s`=0.
- `ready` is registered and equals 1 only in RUN.
- **Channel gating:** a channel is active when state=RUN and `en[i]`=1.
  - Inactive channel: accumulator cleared to 0 and `cen[i]`=0 on the next edge.
- **Active channel, each cycle:** compute sum = acc + mul, using WIDTH+1 bits with no overflow.
  - acc ≥ div (stale value after a runtime `div` decrease): acc←0, `cen`←1.
  - Otherwise, if sum ≥ div: acc←sum−div, `cen`←1.
  - Otherwise: acc←sum, `cen`←0.
  - Invariant after any edge: acc < div.
- **Error cases** (evaluated every cycle, registered, independent of state):
  - div=0: `err`=1, channel held inactive.
  - mul > div: `err`=1, `cen`=1 every active cycle, acc held 0.
  - mul=div: legal; `cen` every cycle, `err`=0.
  - mul=0: legal; never pulses.
- **Runtime changes:** `mul` and `div` are sampled every cycle with no shadow registers; a new value takes effect on the next edge.

## Timing
- `cen` is registered. The pulse is produced on the edge that performs the wrapping accumulation.
- Edge k first samples `locked`=1. Then `lock_s` is high after edge k+1, SETTLE is entered at edge k+2, and `ready` rises at edge k+2+LOCK_DELAY.
- `locked` falls, first sampled at edge j: `ready`, `cen` and accumulators are all 0 after edge j+2. No partial pulse follows.
- `en[i]` rises in RUN at edge m: the first accumulation happens at edge m+1. With mul=div, `cen[i]` is high after edge m+1.
- `rst` asserted mid-operation clears all outputs asynchronously. Release follows the reset-value rules above.
- `locked` glitch shorter than 1 cycle in SETTLE: either a restart or no effect, never a premature `ready`.

## Structure
- Package `cen_gen_pkg`: sequencer state enum (WAIT_LOCK, SETTLE, RUN) and the settle-counter width function clog2(LOCK_DELAY).
- Sub-module `cen_gen_channel`: one accumulator, its compare/subtract logic and its `err` logic. Instantiated CHANNELS times under a generate loop.
- The top level holds the synchroniser, sequencer and settle counter.

## Test plan
- LOCK_DELAY=16, `locked` raised at edge 10 → `ready` high after edge 28; `cen` all 0 before that.
- mul=1, div=8, `en`=1 in RUN → `cen` exactly every 8th cycle (6 MHz from 48 MHz); 1000 pulses over 8000 cycles.
- mul=3, div=8 → pulses follow acc sequence 3,6,1*,4,7,2*,5,0* (*=pulse); 3 pulses per 8 cycles, repeating.
- `locked` dropped for 1 cycle in RUN → `ready` low after 2 edges, accumulators reset; `ready` high again LOCK_DELAY+2 cycles after relock.
- div changed from 100 to 5 while acc=60 → next edge `cen`=1 and acc=0, then period 5/mul.
- div=0 on ch0 and mul=9, div=4 on ch1 → ch0 `err`=1 with no pulses; ch1 `err`=1 with `cen` every cycle; `rst` mid-run clears both immediately.
